// File: rtl/ram_dual_clear.sv
// ram_dual_clear
//   RAM with a single write port and READ_PORTS independent registered read
//   ports. A built-in clear sweep writes CLEAR_VALUE to every location after
//   reset release and whenever `clear` is sampled in READY. The array itself
//   has no reset; the sweep is what guarantees defined contents.
//
// Parameters
//   ADDRESS_BITS  address width, depth = 2**ADDRESS_BITS
//   DATA_BITS     word width
//   READ_PORTS    number of read ports (>= 1)
//   CLEAR_VALUE   word written by the sweep
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low
//   write        write strobe (READY only)
//   address_in   write address
//   data_in      write data
//   clear        request a full clear sweep (READY only)
//   read         per-port read strobe (READY only)
//   address_out  packed read addresses, port i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//   data_out     packed registered read data, port i at [i*DATA_BITS +: DATA_BITS]
//   valid_out    per-port data_out valid, high for one cycle per accepted read
//   busy         clear sweep in progress; this is the FSM state bit itself
//                (1 = CLEAR, 0 = READY), so it doubles as the state debug view
//
// Handshake: there is no back-pressure. A read strobe in READY is always
// accepted and its data appears with valid_out one edge later; strobes while
// busy=1 (or in the cycle `clear` is asserted) are dropped.
//
// Build option
//   RAM_DUAL_CLEAR_BYPASS_EN  defined: a read hitting the address being
//   written in the same cycle returns data_in (write-first). Undefined: it
//   returns the previous contents (read-first).

module ram_dual_clear #(
  parameter int                   ADDRESS_BITS = 4,
  parameter int                   DATA_BITS    = 8,
  parameter int                   READ_PORTS   = 2,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE  = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               write,
  input  logic [ADDRESS_BITS-1:0]            address_in,
  input  logic [DATA_BITS-1:0]               data_in,
  input  logic                               clear,
  input  logic [READ_PORTS-1:0]              read,
  input  logic [READ_PORTS*ADDRESS_BITS-1:0] address_out,
  output logic [READ_PORTS*DATA_BITS-1:0]    data_out,
  output logic [READ_PORTS-1:0]              valid_out,
  output logic                               busy
);

  localparam int                      DEPTH     = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(DEPTH - 1);

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDRESS_BITS-1:0] counter;
  logic [DATA_BITS-1:0]    mem [DEPTH];

  logic                    user_we;
  logic                    mem_we;
  logic [ADDRESS_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0]    mem_wdata;
  logic [READ_PORTS-1:0]   rd_en;
  logic [DATA_BITS-1:0]    rd_word [READ_PORTS];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (state == CLEAR) begin
      if (counter == LAST_ADDR) begin
        state_next = READY;
      end
    end else begin
      if (clear) begin
        state_next = CLEAR;
      end
    end
  end

  // Output / datapath-control logic
  always_comb begin
    user_we   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = address_in;
    mem_wdata = data_in;
    rd_en     = '0;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = counter;
      mem_wdata = CLEAR_VALUE;
    end else begin
      // A clear request wins over any access issued in the same cycle.
      user_we = write && !clear;
      mem_we  = user_we;
      rd_en   = clear ? '0 : read;
    end
  end

  assign busy = (state == CLEAR);

  // Sweep counter: advances on every CLEAR edge and wraps back to 0 on the
  // final address, so it is already 0 when the next sweep starts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter <= '0;
    end else if (state == CLEAR) begin
      counter <= counter + 1'b1;
    end else if (clear) begin
      counter <= '0;
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Per-port read word, with optional same-cycle write forwarding.
  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      rd_word[i] = mem[address_out[i*ADDRESS_BITS +: ADDRESS_BITS]];
`ifdef RAM_DUAL_CLEAR_BYPASS_EN
      if (user_we && (address_in == address_out[i*ADDRESS_BITS +: ADDRESS_BITS])) begin
        rd_word[i] = data_in;
      end
`endif
    end
  end

  // Registered read ports: data holds when a port is not read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      valid_out <= rd_en;
      for (int i = 0; i < READ_PORTS; i++) begin
        if (rd_en[i]) begin
          data_out[i*DATA_BITS +: DATA_BITS] <= rd_word[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dual_clear.sv
module tb_ram_dual_clear;

  localparam int         AB    = 2;
  localparam int         DB    = 8;
  localparam int         RP    = 2;
  localparam int         DEPTH = 4;
  localparam logic [7:0] CV    = 8'hA5;
`ifdef RAM_DUAL_CLEAR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  address_in = '0;
  logic [7:0]  data_in = '0;
  logic        clear = 1'b0;
  logic [1:0]  read = '0;
  logic [3:0]  address_out = '0;
  logic [15:0] data_out;
  logic [1:0]  valid_out;
  logic        busy;

  always #5 clock = ~clock;

  ram_dual_clear #(
    .ADDRESS_BITS(AB),
    .DATA_BITS(DB),
    .READ_PORTS(RP),
    .CLEAR_VALUE(CV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .write(write),
    .address_in(address_in),
    .data_in(data_in),
    .clear(clear),
    .read(read),
    .address_out(address_out),
    .data_out(data_out),
    .valid_out(valid_out),
    .busy(busy)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sweep modelled as a busy-cycle countdown; the array is filled with CV
  // in one go when the countdown expires.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_data [RP];
  logic [1:0] m_valid;
  int         m_busy_left;

  task automatic model_reset();
    m_busy_left = DEPTH;
    m_valid     = '0;
    for (int i = 0; i < RP; i++) m_data[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [1:0] a;
    logic [7:0] d;
    if (m_busy_left > 0) begin
      m_busy_left--;
      m_valid = '0;
      if (m_busy_left == 0) begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = CV;
      end
    end else if (clear) begin
      m_busy_left = DEPTH;
      m_valid     = '0;
    end else begin
      for (int i = 0; i < RP; i++) begin
        if (read[i]) begin
          a = address_out[i*AB +: AB];
          d = (BYP && write && (address_in == a)) ? data_in : m_mem[a];
          m_data[i]  = d;
          m_valid[i] = 1'b1;
          exp_q.push_back(d);
        end else begin
          m_valid[i] = 1'b0;
        end
      end
      if (write) m_mem[address_in] = data_in;
    end
  endtask

  task automatic check_model(input string name);
    logic [7:0] e;
    check({name, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({name, ".busy"}, 32'(busy), 32'(m_busy_left > 0));
    for (int i = 0; i < RP; i++) begin
      if (m_valid[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s.queue: got empty expected entry", name);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s.data%0d", name, i), 32'(data_out[i*DB +: DB]), 32'(e));
        end
      end else begin
        check($sformatf("%s.hold%0d", name, i), 32'(data_out[i*DB +: DB]), 32'(m_data[i]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    write = 1'b0;
    clear = 1'b0;
    read  = '0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       wr;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] rd;
    logic [1:0] ra0;
    logic [1:0] ra1;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] ev;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 2'd0, 8'h00, 2'b11, 2'd0, 2'd1, CV,    CV,    2'b11};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 2'b11, 2'd2, 2'd3, CV,    CV,    2'b11};
    vecs[2] = '{1'b1, 2'd2, 8'h3C, 2'b00, 2'd0, 2'd0, CV,    CV,    2'b00};
    vecs[3] = '{1'b0, 2'd0, 8'h00, 2'b11, 2'd2, 2'd1, 8'h3C, CV,    2'b11};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 2'b00, 2'd0, 2'd0, 8'h3C, CV,    2'b00};
    vecs[5] = '{1'b1, 2'd1, 8'h11, 2'b00, 2'd0, 2'd0, 8'h3C, CV,    2'b00};
    vecs[6] = '{1'b1, 2'd1, 8'h22, 2'b01, 2'd1, 2'd0, BYP ? 8'h22 : 8'h11, CV, 2'b01};
    vecs[7] = '{1'b0, 2'd0, 8'h00, 2'b11, 2'd1, 2'd1, 8'h22, 8'h22, 2'b11};

    // Reset held: outputs at reset values.
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst.data", 32'(data_out), 32'h0);
    check("rst.valid", 32'(valid_out), 32'h0);
    check("rst.busy", 32'(busy), 32'h1);

    // Release: busy for exactly DEPTH edges.
    reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      check($sformatf("rel.busy%0d", k), 32'(busy), 32'(k < DEPTH));
      check_model("rel");
    end

    // Table-driven directed vectors.
    for (int v = 0; v < 8; v++) begin
      write       = vecs[v].wr;
      address_in  = vecs[v].wa;
      data_in     = vecs[v].wd;
      read        = vecs[v].rd;
      address_out = {vecs[v].ra1, vecs[v].ra0};
      cycle();
      check($sformatf("vec%0d.d0", v), 32'(data_out[7:0]), 32'(vecs[v].e0));
      check($sformatf("vec%0d.d1", v), 32'(data_out[15:8]), 32'(vecs[v].e1));
      check($sformatf("vec%0d.v", v), 32'(valid_out), 32'(vecs[v].ev));
      check($sformatf("vec%0d.busy", v), 32'(busy), 32'h0);
      check_model($sformatf("vec%0d", v));
    end

    // Clear with a simultaneous write: write dropped, accesses ignored.
    clear = 1'b1; write = 1'b1; address_in = 2'd0; data_in = 8'h77;
    read = 2'b11; address_out = 4'h0;
    cycle();
    check("clr.busy0", 32'(busy), 32'h1);
    check("clr.valid0", 32'(valid_out), 32'h0);
    check_model("clr0");
    clear = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      check($sformatf("clr.busy%0d", k), 32'(busy), 32'(k < DEPTH));
      check($sformatf("clr.valid%0d", k), 32'(valid_out), 32'h0);
      check_model("clr");
    end
    set_idle();
    read = 2'b01; address_out = 4'h0;
    cycle();
    check("clr.addr0", 32'(data_out[7:0]), 32'(CV));
    check_model("clr.rd");

    // Reset two cycles into a sweep.
    set_idle();
    write = 1'b1; address_in = 2'd3; data_in = 8'h5A;
    cycle();
    check_model("pre.wr");
    clear = 1'b1; write = 1'b0;
    cycle();
    check_model("mid0");
    clear = 1'b0;
    cycle();
    check_model("mid1");
    reset = 1'b0;
    model_reset();
    #1;
    check("mid.rst.data", 32'(data_out), 32'h0);
    check("mid.rst.valid", 32'(valid_out), 32'h0);
    check("mid.rst.busy", 32'(busy), 32'h1);
    @(posedge clock);
    #1;
    check("mid.rst.hold", 32'(busy), 32'h1);
    reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      check($sformatf("mid.busy%0d", k), 32'(busy), 32'(k < DEPTH));
      check_model("mid.rel");
    end
    for (int a = 0; a < DEPTH; a++) begin
      read = 2'b11;
      address_out = {2'(DEPTH - 1 - a), 2'(a)};
      cycle();
      check($sformatf("mid.rd%0d.p0", a), 32'(data_out[7:0]), 32'(CV));
      check($sformatf("mid.rd%0d.p1", a), 32'(data_out[15:8]), 32'(CV));
      check_model("mid.rd");
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      write       = 1'($urandom_range(0, 1));
      address_in  = 2'($urandom_range(0, 3));
      data_in     = 8'($urandom_range(0, 255));
      clear       = ($urandom_range(0, 39) == 0);
      read        = 2'($urandom_range(0, 3));
      address_out = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) address_out[1:0] = address_in;
      cycle();
      check_model("rand");
    end

    set_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_dual_clear.md
# ram_dual_clear

Parametrised dual-port RAM with one write port, `READ_PORTS` independent registered read ports, per-port read-valid, and a built-in clear sequencer that sweeps every location to `CLEAR_VALUE` after reset or on request. It is the general-purpose storage primitive for register files, lookup tables and scratch buffers. A self-clearing array means consumers never read uninitialised contents, without an asynchronous reset on the array itself.

## Interface
- `ADDRESS_BITS`, default 4, address width; depth is 2^ADDRESS_BITS.
- `DATA_BITS`, default 8, word width.
- `READ_PORTS`, default 2, number of read ports (>=1).
- `CLEAR_VALUE`, default 0, DATA_BITS-wide value written by the clear sweep.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately, release is sampled on `clock`.
- `write`  in  1  write strobe.
- `address_in`  in  ADDRESS_BITS  write address.
- `data_in`  in  DATA_BITS  write data.
- `clear`  in  1  request a full clear sweep.
- `read`  in  READ_PORTS  per-port read strobe.
- `address_out`  in  READ_PORTS*ADDRESS_BITS  packed read addresses; port i is at bits [i*ADDRESS_BITS +: ADDRESS_BITS].
- `data_out`  out  READ_PORTS*DATA_BITS  packed registered read data; port i is at bits [i*DATA_BITS +: DATA_BITS].
- `valid_out`  out  READ_PORTS  per-port data_out valid.
- `busy`  out  1  clear sweep in progress.

## Operation
- FSM states: CLEAR, READY.
- Reset (`reset`=0):
  - state=CLEAR, sweep counter=0, busy=1.
  - data_out all 0, valid_out all 0.
  - Array contents are not reset directly.
- CLEAR:
  - Each rising edge writes CLEAR_VALUE to mem[counter], then counter increments.
  - After the edge that writes address 2^ADDRESS_BITS-1, state goes to READY, busy=0, and counter wraps to 0.
  - `write`, `read` and `clear` are ignored. valid_out=0 and data_out holds.
- READY:
  - `write`=1: mem[address_in] <= data_in at the edge.
  - For each port i, `read[i]`=1: data_out[i] <= mem[address_out[i]] and valid_out[i] <= 1 at the edge.
  - For each port i, `read[i]`=0: valid_out[i] <= 0 and data_out[i] holds.
  - Multiple ports may read the same address in the same cycle; all return identical data.
  - `clear`=1: at the edge, state goes to CLEAR, counter=0, busy=1. A write in the same cycle is dropped and all valid_out go to 0.
- Read-during-write, same address, same cycle: returns the old contents, unless bypass is compiled in (see Configuration).
- Reset asserted mid-sweep or mid-read: immediate return to the reset state; the sweep restarts from address 0 after release.

## Timing
- Read latency 1 cycle: strobe at edge N puts data and valid on the outputs after edge N.
- Write is visible to a read issued on the following cycle.
- Clear sweep lasts exactly 2^ADDRESS_BITS cycles. busy deasserts after the 2^ADDRESS_BITS-th rising edge after reset release or after `clear` is sampled. The first usable access is on the next edge.
- `busy` is registered; no combinational path from inputs to outputs (except with bypass, which is still registered at data_out).

## Configuration
- Macro: `RAM_DUAL_CLEAR_BYPASS_EN`.
- Defined: a read in READY to the same address as a simultaneous write returns data_in (write-first forwarding), per port.
- Undefined: the same read returns the previous contents (read-first).
- All other behaviour is identical in both builds.

## Test plan
Configuration for all scenarios: ADDRESS_BITS=2, DATA_BITS=8, READ_PORTS=2, CLEAR_VALUE=8'hA5.

- Reset then release:
  - busy=1 for exactly 4 edges, then 0.
  - Reading addresses 0..3 on both ports returns 8'hA5 with valid_out=2'b11 one cycle later.
- Write then read:
  - Write 8'h3C to address 2, then on the next cycle read port0 addr 2 and port1 addr 1.
  - Response: data_out port0=8'h3C, port1=8'hA5, valid_out=2'b11.
  - Next cycle with read=0: valid_out=2'b00 and data held.
- Read-during-write:
  - Address 1 holds 8'h11; write 8'h22 to address 1 while port0 reads address 1.
  - Response: port0=8'h11 without the macro, 8'h22 with it.
  - A subsequent read returns 8'h22 in both builds.
- Clear with simultaneous write:
  - Assert `clear` and write 8'h77 to address 0 in the same cycle.
  - Response: busy=1 for 4 cycles; writes and reads during the sweep are ignored with valid_out=0; afterwards address 0 reads 8'hA5.
- Reset mid-sweep:
  - Drive `reset` low two cycles into a sweep, then release.
  - Response: outputs go to zero immediately; busy stays 1 for a full 4 cycles after release; all addresses read 8'hA5.
